// File: rtl/axis_serializer_arbiter_pkg.sv
// Shared definitions for the stream-sharing blocks: arbiter state encoding
// and constant-width helpers.
package axis_defs;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Ceiling log2; constant-evaluable so it can size ports and counters.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned word_width(input int unsigned nb, input int unsigned w);
        return nb * w;
    endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping
// modulo NB_PORTS.
module axis_rr_picker
    import axis_defs::*;
#(
    parameter int unsigned NB_PORTS = 4,
    parameter int unsigned ID_WIDTH = clog2(NB_PORTS)
) (
    input  logic [NB_PORTS-1:0] i_req,
    input  logic [ID_WIDTH-1:0] i_ptr,
    output logic [ID_WIDTH-1:0] o_idx,
    output logic                o_any
);

    // Walk from the farthest candidate to the nearest so the nearest set
    // request is the last one written and wins.
    always_comb begin
        o_any = |i_req;
        o_idx = '0;
        for (int unsigned k = NB_PORTS; k >= 1; k--) begin
            int unsigned         c;
            logic [ID_WIDTH-1:0] idx;
            c = 32'(i_ptr) + k;
            if (c >= NB_PORTS) begin
                c = c - NB_PORTS;
            end
            idx = ID_WIDTH'(c);
            if (i_req[idx]) begin
                o_idx = idx;
            end
        end
    end

endmodule

// File: rtl/axis_serializer_arbiter.sv
// Round-robin arbiter sharing one serializer between NB_PORTS wide-word
// AXI-Stream requesters; a grant lasts one packet or BURST_MAX words.
module axis_serializer_arbiter
    import axis_defs::*;
#(
    parameter int unsigned NB_PORTS   = 4,
    parameter int unsigned DATA_NB    = 3,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_MAX  = 16,
    parameter int unsigned ID_WIDTH   = clog2(NB_PORTS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NB_PORTS*DATA_NB*DATA_WIDTH-1:0] up_data,
    input  logic [NB_PORTS-1:0]                    up_valid,
    input  logic [NB_PORTS-1:0]                    up_last,
    output logic [NB_PORTS-1:0]                    up_ready,
    output logic [DATA_NB*DATA_WIDTH-1:0]          down_data,
    output logic                                   down_valid,
    input  logic                                   down_ready,
    output logic                                   down_last,
    output logic [ID_WIDTH-1:0]                    down_id
);

    localparam int unsigned         W        = word_width(DATA_NB, DATA_WIDTH);
    localparam int unsigned         CNT_W    = clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic [ID_WIDTH-1:0] PTR_RST  = ID_WIDTH'(NB_PORTS - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [ID_WIDTH-1:0] r_grant;
    logic [ID_WIDTH-1:0] r_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [ID_WIDTH-1:0] w_pick;
    logic                w_any;
    logic                w_gvalid;
    logic                w_glast;
    logic                w_xfer;
    logic                w_release;
    logic [W-1:0]        w_words [NB_PORTS];

    for (genvar p = 0; p < NB_PORTS; p++) begin : g_words
        assign w_words[p] = up_data[p*W +: W];
    end

    axis_rr_picker #(
        .NB_PORTS (NB_PORTS),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .i_req (up_valid),
        .i_ptr (r_ptr),
        .o_idx (w_pick),
        .o_any (w_any)
    );

    always_comb begin
        w_gvalid    = up_valid[r_grant];
        w_glast     = up_last[r_grant];
        w_xfer      = (r_state == ST_GRANT) && w_gvalid && down_ready;
        w_release   = w_xfer && (w_glast || (r_cnt == CNT_LAST));
        w_state_nxt = r_state;
        down_data   = '0;
        down_valid  = 1'b0;
        down_last   = 1'b0;
        down_id     = '0;
        up_ready    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                down_data         = w_words[r_grant];
                down_valid        = w_gvalid;
                down_last         = w_glast;
                down_id           = r_grant;
                up_ready[r_grant] = down_ready;
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Grant only changes from IDLE, which keeps down_id/down_data stable
    // for the whole grant, including stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_cnt   <= '0;
            r_ptr   <= PTR_RST;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_any) begin
                r_grant <= w_pick;
                r_cnt   <= '0;
            end
            if (w_release) begin
                r_ptr <= r_grant;
                r_cnt <= '0;
            end else if (w_xfer) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_serializer_arbiter.sv
// Directed self-checking bench for axis_serializer_arbiter (4 ports, BURST_MAX=4).
module tb_axis_serializer_arbiter;

    localparam int NP = 4;
    localparam int W  = 24;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NP*W-1:0]  up_data = '0;
    logic [NP-1:0]    up_valid = '0;
    logic [NP-1:0]    up_last = '0;
    logic [NP-1:0]    up_ready;
    logic [W-1:0]     down_data;
    logic             down_valid;
    logic             down_ready = 1'b0;
    logic             down_last;
    logic [1:0]       down_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axis_serializer_arbiter #(
        .NB_PORTS   (4),
        .DATA_NB    (3),
        .DATA_WIDTH (8),
        .BURST_MAX  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_last    (up_last),
        .up_ready   (up_ready),
        .down_data  (down_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_last  (down_last),
        .down_id    (down_id)
    );

    function automatic logic [W-1:0] word(input int p, input int i);
        return {8'(p), 8'(i), 8'hA5};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input int i, input logic last);
        up_data[p*W +: W] = word(p, i);
        up_last[p]        = last;
        up_valid[p]       = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(down_valid), 32'd0);
        chk({tag, ".ready"}, 32'(up_ready), 32'd0);
    endtask

    task automatic chk_grant(input string tag, input int p, input logic [W-1:0] d,
                             input logic last, input logic rdy);
        chk({tag, ".valid"}, 32'(down_valid), 32'd1);
        chk({tag, ".id"}, 32'(down_id), 32'(p));
        chk({tag, ".data"}, 32'(down_data), 32'(d));
        chk({tag, ".last"}, 32'(down_last), 32'(last));
        chk({tag, ".ready"}, 32'(up_ready), rdy ? (32'd1 << p) : 32'd0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        up_valid   = '0;
        up_last    = '0;
        down_ready = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    int exp_port [12] = '{1, 1, 1, 1, 3, 1, 1, 1, 1, 3, 1, 1};
    bit bubble   [12] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
    bit rdy_seq  [6]  = '{1, 0, 1, 1, 0, 1};

    initial begin
        int i0;
        int i1;
        int i3;
        int p;

        // Reset state
        do_reset();
        #1;
        chk_idle("rst");
        chk("rst.id", 32'(down_id), 32'd0);
        chk("rst.data", 32'(down_data), 32'd0);
        chk("rst.last", 32'(down_last), 32'd0);

        // Single requester, port 2, 3-word packet
        down_ready = 1'b1;
        drive(2, 0, 1'b0);
        #1 chk_idle("t1.arb");
        cyc();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) drive(2, k, k == 2);
            #1 chk_grant($sformatf("t1.w%0d", k), 2, word(2, k), k == 2, 1'b1);
            cyc();
        end
        up_valid = '0;
        #1 chk_idle("t1.end");

        // All ports valid, 1-word packets: 0,1,2,3,0,1 with bubbles
        do_reset();
        for (int q = 0; q < NP; q++) drive(q, 0, 1'b1);
        down_ready = 1'b1;
        for (int g = 0; g < 6; g++) begin
            #1 chk_idle($sformatf("t2.bub%0d", g));
            cyc();
            #1 chk_grant($sformatf("t2.g%0d", g), g % NP, word(g % NP, 0), 1'b1, 1'b1);
            cyc();
        end
        up_valid = '0;

        // Burst split: port 1 10-word packet vs port 3 single-word packets
        do_reset();
        drive(1, 0, 1'b0);
        drive(3, 0, 1'b1);
        down_ready = 1'b1;
        i1 = 0;
        i3 = 0;
        for (int i = 0; i < 12; i++) begin
            p = exp_port[i];
            if (bubble[i]) begin
                #1 chk_idle($sformatf("t3.bub%0d", i));
                cyc();
            end
            #1 chk_grant($sformatf("t3.x%0d", i), p, (p == 1) ? word(1, i1) : word(3, i3),
                         (p == 1) ? (i1 == 9) : 1'b1, 1'b1);
            cyc();
            if (p == 1) begin
                i1++;
                if (i1 < 10) drive(1, i1, i1 == 9);
                else up_valid[1] = 1'b0;
            end else begin
                i3++;
                if (i3 < 2) drive(3, i3, 1'b1);
                else up_valid[3] = 1'b0;
            end
        end
        #1 chk_idle("t3.end");

        // down_ready toggling during a grant on port 0
        do_reset();
        down_ready = 1'b1;
        drive(0, 0, 1'b0);
        #1 chk_idle("t4.arb");
        cyc();
        i0 = 0;
        for (int c = 0; c < 6; c++) begin
            down_ready = rdy_seq[c];
            #1 chk_grant($sformatf("t4.c%0d", c), 0, word(0, i0), i0 == 3, rdy_seq[c]);
            cyc();
            if (rdy_seq[c]) begin
                i0++;
                if (i0 < 4) drive(0, i0, i0 == 3);
                else up_valid[0] = 1'b0;
            end
        end
        #1 chk_idle("t4.end");

        // Reset mid-packet on port 3, then port 0 wins
        do_reset();
        down_ready = 1'b1;
        drive(3, 0, 1'b0);
        #1 chk_idle("t5.arb");
        cyc();
        #1 chk_grant("t5.w0", 3, word(3, 0), 1'b0, 1'b1);
        cyc();
        drive(3, 1, 1'b0);
        drive(0, 0, 1'b1);
        #1 chk_grant("t5.w1", 3, word(3, 1), 1'b0, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1 chk_idle("t5.rst");
        chk("t5.rst.id", 32'(down_id), 32'd0);
        chk("t5.rst.data", 32'(down_data), 32'd0);
        chk("t5.rst.last", 32'(down_last), 32'd0);
        cyc();
        #1 chk_grant("t5.p0", 0, word(0, 0), 1'b1, 1'b1);
        cyc();
        up_valid = '0;

        // Granted port 1 drops valid for 5 cycles while port 2 waits
        do_reset();
        down_ready = 1'b1;
        drive(1, 0, 1'b0);
        drive(2, 0, 1'b1);
        #1 chk_idle("t6.arb");
        cyc();
        #1 chk_grant("t6.w0", 1, word(1, 0), 1'b0, 1'b1);
        cyc();
        drive(1, 1, 1'b1);
        up_valid[1] = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk($sformatf("t6.hold%0d.valid", s), 32'(down_valid), 32'd0);
            chk($sformatf("t6.hold%0d.ready", s), 32'(up_ready), 32'b0010);
            chk($sformatf("t6.hold%0d.id", s), 32'(down_id), 32'd1);
            cyc();
        end
        up_valid[1] = 1'b1;
        #1 chk_grant("t6.w1", 1, word(1, 1), 1'b1, 1'b1);
        cyc();
        up_valid[1] = 1'b0;
        #1 chk_idle("t6.bub");
        cyc();
        #1 chk_grant("t6.p2", 2, word(2, 0), 1'b1, 1'b1);
        cyc();
        up_valid = '0;
        #1 chk_idle("t6.end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_serializer_arbiter.md
Name: axis_serializer_arbiter

Overview:
- Round-robin arbiter that shares one axis_serializer between NB_PORTS upstream wide-word AXI-Stream requesters.
- Sits directly in front of the serializer's up_* port and forwards the granted requester's wide words unchanged.
- Tags every forwarded word with the source port index so the downstream side can demultiplex results.
- Holds a grant for one packet (until up_last) or for BURST_MAX words, whichever comes first, so no requester can starve the others.

Parameters:
- NB_PORTS, 4, number of upstream requesters (legal range 2..16).
- DATA_NB, 3, narrow beats per wide word; matches the serializer's DATA_NB.
- DATA_WIDTH, 8, bits per narrow beat; wide word is DATA_NB*DATA_WIDTH bits.
- BURST_MAX, 16, maximum wide words per grant (legal range 1..256).
- ID_WIDTH, clog2(NB_PORTS), width of the port index.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- up_data  in  NB_PORTS*DATA_NB*DATA_WIDTH  packed wide words; port p occupies slice [p*W +: W].
- up_valid  in  NB_PORTS  per-port valid.
- up_last  in  NB_PORTS  per-port end-of-packet flag, qualified by valid.
- up_ready  out  NB_PORTS  per-port ready; one-hot or zero.
- down_data  out  DATA_NB*DATA_WIDTH  granted word, to the serializer's up_data.
- down_valid  out  1  to the serializer's up_valid.
- down_ready  in  1  from the serializer's up_ready.
- down_last  out  1  granted port's up_last.
- down_id  out  ID_WIDTH  index of the granted port.

Behaviour:
- Reset values:
  - state = IDLE; grant = 0; burst count = 0.
  - rr_ptr = NB_PORTS-1, so port 0 has the highest priority first.
  - Outputs: down_valid=0, up_ready=0, down_last=0, down_id=0, down_data=0.
- State machine, 2 states:
  - IDLE:
    - down_valid=0, up_ready=0.
    - If any up_valid is set, pick the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NB_PORTS.
    - Register the pick as grant, clear the burst count, go to GRANT.
    - Arbitration costs exactly 1 cycle; no grant is issued in the same cycle the request is seen.
  - GRANT: combinational pass-through of the granted port.
    - down_data = up_data slice[grant].
    - down_valid = up_valid[grant].
    - down_last = up_last[grant].
    - down_id = grant.
    - up_ready = down_ready on bit [grant] only; all other bits are 0.
- Transfer: a transfer occurs when down_valid & down_ready; it increments the burst count.
- Release happens on a transfer when either up_last[grant]=1 or burst count = BURST_MAX-1. On release:
  - go to IDLE;
  - set rr_ptr = grant;
  - clear the burst count.
- Release resets the burst count, so a packet longer than BURST_MAX is split across grants.
  - Each chunk ends with down_last=0 except the chunk carrying the real last word.
- Back-to-back: after a release there is always one IDLE cycle, so the bubble between grants is exactly 1 cycle.
- Granted valid drops mid-grant: hold the grant and wait. There is no timeout.
- Non-granted ports see up_ready=0 and must hold their data.
- down_ready low: the burst count and grant are frozen.
- Ports other than grant are never observed while in GRANT.
- Reset asserted mid-grant: the next cycle is IDLE with all outputs at reset values.
  - A partial packet is abandoned; upstream and the serializer are reset by the same rst.
- down_id and down_data are stable whenever down_valid=1 && down_ready=0; this holds because grant is constant in GRANT.
- Width rules:
  - The burst counter is clog2(BURST_MAX+1) bits.
  - rr_ptr and grant are ID_WIDTH bits.
  - When NB_PORTS is not a power of 2, the modulo wrap is explicit.

Decomposition:
- Shared package/header `axis_defs`:
  - clog2 function;
  - IDLE/GRANT state encodings;
  - wide-word width macro DATA_NB*DATA_WIDTH.
- One sub-module `axis_rr_picker`: purely combinational.
  - Inputs: request vector and rr_ptr.
  - Outputs: chosen index and an any_req flag.
  - Reusable by other shared stream resources.

Test Plan:
- Single requester, port 2, 3-word packet with last on word 3, down_ready=1 → 1 idle cycle, then 3 transfers with down_id=2, down_last only on the third; port 2 up_ready high for 3 cycles; then IDLE.
- All 4 ports valid continuously, 1-word packets (last=1) → grant order 0,1,2,3,0,1..., one word per grant, a 1-cycle bubble between grants.
- BURST_MAX=4, port 1 sends a 10-word packet while port 3 is also valid → order: port 1 words 0-3, port 3 (its packet), port 1 words 4-7, port 3, port 1 words 8-9; down_last only on word 9.
- down_ready toggling 1,0,1,1,0 during a grant on port 0 → down_data and down_id held while stalled, burst count advances only on ready cycles, no words lost or duplicated (scoreboard compares per-port order).
- rst pulsed for 1 cycle mid-packet on port 3 → next cycle: down_valid=0, up_ready=0000; after reset, the first grant goes to port 0 if it is valid.
- Granted port 1 drops up_valid for 5 cycles mid-packet while port 2 is valid → grant stays on port 1, port 2 up_ready=0 throughout, transfer resumes when port 1 re-asserts valid.
